// File: rtl/multicycle_control_fsm_if.sv
// multicycle_control_fsm_if
//   Bundle between the multi-cycle sequencing controller and the datapath.
//   master: controller side (reads opcode/flags/handshake, drives controls)
//   slave : datapath side (drives opcode/flags/handshake, reads controls)
//   Signals:
//     instr_op[5:0]  opcode from IR[31:26]
//     zero           ALU zero flag
//     mem_ready      memory completes current read/write this cycle
//     pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
//     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b[1:0],
//     alu_op[1:0], pc_source[1:0]   datapath mux selects and enables
interface multicycle_control_fsm_if;
  logic [5:0] instr_op;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       pc_write_cond;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       mem_to_reg;
  logic       reg_dst;
  logic       reg_write;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_source;

  modport master (
    input  instr_op, zero, mem_ready,
    output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source
  );

  modport slave (
    output instr_op, zero, mem_ready,
    input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
           pc_source
  );
endinterface

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm
//   Sequencing controller for the multi-cycle CPU datapath. Steps shared
//   ALU, register file, PC and unified memory through fetch, decode,
//   execute, memory and write-back; stalls on mem_ready; counts retired
//   instructions.
//   Parameters:
//     CNT_W       width of the retired-instruction counter (default 16)
//   Ports:
//     clk         rising-edge clock
//     rst_n       synchronous reset, active low (forces all outputs to 0)
//     bus         multicycle_control_fsm_if.master (opcode, zero, mem_ready
//                 in; datapath controls out)
//     illegal_op  one-cycle pulse in DECODE on an unsupported opcode
//     retired     retired-instruction count (wraps)
//     state       current state encoding (debug)
//   Build option:
//     MC_JUMP_EN  when defined, opcode 6'h02 (J) is executed via the JUMP
//                 state; otherwise J is treated as illegal.
module multicycle_control_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  multicycle_control_fsm_if.master bus,
  output logic                     illegal_op,
  output logic [CNT_W-1:0]         retired,
  output logic [3:0]               state
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EXEC   = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_I_EXEC   = 4'd8;
  localparam logic [3:0] S_I_WB     = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
`ifdef MC_JUMP_EN
  localparam logic [3:0] S_JUMP     = 4'd11;
  localparam logic [5:0] OP_J       = 6'h02;
`endif

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
  } ctrl_t;

  logic [3:0]       state_q;
  logic [3:0]       next_state;
  logic [CNT_W-1:0] retired_q;
  ctrl_t            ctrl_d;
  logic             illegal_d;
  logic             retire;

  always_comb begin
    next_state = state_q;
    ctrl_d     = '0;
    illegal_d  = 1'b0;
    retire     = 1'b0;
    case (state_q)
      S_FETCH: begin
        ctrl_d.mem_read = 1'b1;
        // IR/PC strobes only in the cycle memory delivers the word
        if (bus.mem_ready) begin
          ctrl_d.ir_write  = 1'b1;
          ctrl_d.pc_write  = 1'b1;
          ctrl_d.alu_src_b = 2'b01;
          next_state       = S_DECODE;
        end
      end
      S_DECODE: begin
        ctrl_d.alu_src_b = 2'b11;
        case (bus.instr_op)
          OP_LW, OP_SW: next_state = S_MEM_ADDR;
          OP_RTYPE:     next_state = S_R_EXEC;
          OP_ADDI:      next_state = S_I_EXEC;
          OP_BEQ:       next_state = S_BRANCH;
`ifdef MC_JUMP_EN
          OP_J:         next_state = S_JUMP;
`endif
          default: begin
            illegal_d  = 1'b1;
            next_state = S_FETCH;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
        next_state = (bus.instr_op == OP_SW) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl_d.mem_read = 1'b1;
        ctrl_d.i_or_d   = 1'b1;
        if (bus.mem_ready) next_state = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = 1'b1;
        retire            = 1'b1;
        next_state        = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl_d.mem_write = 1'b1;
        ctrl_d.i_or_d    = 1'b1;
        if (bus.mem_ready) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end
      end
      S_R_EXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_op    = 2'b10;
        next_state       = S_R_WB;
      end
      S_R_WB: begin
        ctrl_d.reg_write = 1'b1;
        ctrl_d.reg_dst   = 1'b1;
        retire           = 1'b1;
        next_state       = S_FETCH;
      end
      S_I_EXEC: begin
        ctrl_d.alu_src_a = 1'b1;
        ctrl_d.alu_src_b = 2'b10;
        next_state       = S_I_WB;
      end
      S_I_WB: begin
        ctrl_d.reg_write = 1'b1;
        retire           = 1'b1;
        next_state       = S_FETCH;
      end
      S_BRANCH: begin
        ctrl_d.alu_src_a     = 1'b1;
        ctrl_d.alu_op        = 2'b01;
        ctrl_d.pc_write_cond = 1'b1;
        ctrl_d.pc_source     = 2'b01;
        retire               = 1'b1;
        next_state           = S_FETCH;
      end
`ifdef MC_JUMP_EN
      S_JUMP: begin
        ctrl_d.pc_write  = 1'b1;
        ctrl_d.pc_source = 2'b10;
        retire           = 1'b1;
        next_state       = S_FETCH;
      end
`endif
      default: next_state = S_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      retired_q <= '0;
    end else begin
      state_q <= next_state;
      if (retire) retired_q <= retired_q + CNT_W'(1);
    end
  end

  // Outputs are gated by rst_n so nothing (not even the fetch read) leaks
  // out while reset is held, regardless of the registered state.
  assign {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
          bus.mem_write, bus.ir_write, bus.mem_to_reg, bus.reg_dst,
          bus.reg_write, bus.alu_src_a, bus.alu_src_b, bus.alu_op,
          bus.pc_source} = rst_n ? ctrl_d : '0;
  assign illegal_op = rst_n & illegal_d;
  assign retired    = rst_n ? retired_q : '0;
  assign state      = rst_n ? state_q : '0;

endmodule
